// File: rtl/pll_reset_sequencer.sv
// Holds the downstream domain in reset until the PLL has reported lock for a
// stable window plus a hold period, and counts lock losses seen while running.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_WIDTH    = 8
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  locked,
    input  logic                  clear_loss,
    output logic                  sys_resetn,
    output logic                  sys_reset,
    output logic                  ready,
    output logic [1:0]            state,
    output logic [LOSS_WIDTH-1:0] loss_count
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'b00,
        ST_STABLE = 2'b01,
        ST_HOLD   = 2'b10,
        ST_RUN    = 2'b11
    } state_t;

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   lock_s;
    state_t                 state_r;
    state_t                 next_state_s;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       next_cnt_s;
    logic                   loss_event_s;
    logic                   run_next_s;
    logic [LOSS_WIDTH-1:0]  next_loss_s;
    logic                   sys_resetn_r;
    logic                   sys_reset_r;
    logic                   ready_r;
    logic [LOSS_WIDTH-1:0]  loss_count_r;

    // Lock synchronizer: the asynchronous lock flag enters the clock domain here only.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], locked};
        end
    end

    assign lock_s = sync_r[SYNC_STAGES-1];

    // State and interval counter register.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_WAIT;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
        end
    end

    // Next-state logic: any loss of lock before RUN restarts the whole sequence.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = {CNT_W{1'b0}};
        loss_event_s = 1'b0;
        case (state_r)
            ST_WAIT: begin
                if (lock_s) begin
                    next_state_s = ST_STABLE;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    next_state_s = ST_WAIT;
                end else if (cnt_r == STABLE_LAST) begin
                    next_state_s = ST_HOLD;
                end else begin
                    next_cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (!lock_s) begin
                    next_state_s = ST_WAIT;
                end else if (cnt_r == HOLD_LAST) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    next_state_s = ST_WAIT;
                    loss_event_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            default: begin
                next_state_s = ST_WAIT;
            end
        endcase
    end

    // Output decode: values for the output flops, taken from the next state so
    // the outputs change on the same edge as the state register.
    always_comb begin
        run_next_s = (next_state_s == ST_RUN);
        if (clear_loss) begin
            next_loss_s = loss_event_s ? LOSS_WIDTH'(1) : {LOSS_WIDTH{1'b0}};
        end else if (loss_event_s && (loss_count_r != {LOSS_WIDTH{1'b1}})) begin
            next_loss_s = loss_count_r + LOSS_WIDTH'(1);
        end else begin
            next_loss_s = loss_count_r;
        end
    end

    // Output flops; the async clear makes reset reach the downstream domain at once.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sys_resetn_r <= 1'b0;
            sys_reset_r  <= 1'b1;
            ready_r      <= 1'b0;
            loss_count_r <= {LOSS_WIDTH{1'b0}};
        end else begin
            sys_resetn_r <= run_next_s;
            sys_reset_r  <= ~run_next_s;
            ready_r      <= run_next_s;
            loss_count_r <= next_loss_s;
        end
    end

    assign sys_resetn = sys_resetn_r;
    assign sys_reset  = sys_reset_r;
    assign ready      = ready_r;
    assign state      = state_r;
    assign loss_count = loss_count_r;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Randomised self-checking bench for pll_reset_sequencer with a run-length
// reference model (STABLE=8, HOLD=4, SYNC=2, LOSS_WIDTH=8).
module tb_pll_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int STABLE = 8;
    localparam int HOLD   = 4;
    localparam int RUN_AT = STABLE + HOLD + 1;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       locked = 1'b0;
    logic       clear_loss = 1'b0;
    logic       sys_resetn;
    logic       sys_reset;
    logic       ready;
    logic [1:0] state;
    logic [7:0] loss_count;

    int n_vec = 0;
    int n_err = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE), .HOLD_CYCLES(HOLD), .LOSS_WIDTH(8)
    ) dut (
        .clock(clock), .resetn(resetn), .locked(locked), .clear_loss(clear_loss),
        .sys_resetn(sys_resetn), .sys_reset(sys_reset), .ready(ready),
        .state(state), .loss_count(loss_count)
    );

    always #5 clock = ~clock;

    // Reference model: lock_s is locked delayed by SYNC samples; the state
    // follows from how many consecutive edges lock_s has been high.
    logic [SYNC-1:0] hist = '0;
    int              run_len = 0;
    logic [7:0]      m_loss = 8'd0;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            hist    <= '0;
            run_len <= 0;
            m_loss  <= 8'd0;
        end else begin
            hist <= {hist[SYNC-2:0], locked};
            if (hist[SYNC-1]) begin
                run_len <= (run_len < RUN_AT) ? run_len + 1 : run_len;
            end else begin
                run_len <= 0;
            end
            if (clear_loss) begin
                m_loss <= (!hist[SYNC-1] && run_len >= RUN_AT) ? 8'd1 : 8'd0;
            end else if (!hist[SYNC-1] && run_len >= RUN_AT && m_loss != 8'hff) begin
                m_loss <= m_loss + 8'd1;
            end
        end
    end

    function automatic logic [1:0] exp_state(int r);
        if (r == 0)                   return 2'b00;
        else if (r <= STABLE)         return 2'b01;
        else if (r <= STABLE + HOLD)  return 2'b10;
        else                          return 2'b11;
    endfunction

    logic [12:0] exp_vec;
    logic [12:0] dut_vec;
    assign exp_vec = {exp_state(run_len), run_len >= RUN_AT, run_len < RUN_AT, run_len >= RUN_AT, m_loss};
    assign dut_vec = {state, sys_resetn, sys_reset, ready, loss_count};

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic hold_reset();
        resetn = 1'b0;
        cyc();
        cyc();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        logic [12:0] rst_vec;
        rst_vec = 13'b00_0_1_0_00000000;
        locked = 1'b1;
        resetn = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_vec++;
            if (dut_vec !== rst_vec) begin
                n_err++;
                $display("FAIL reset_state: got %b expected %b", dut_vec, rst_vec);
            end
        end
        resetn = 1'b1;
    endtask

    task automatic test_startup();
        locked = 1'b1;
        hold_reset();
        for (int e = 1; e <= 20; e++) begin
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL startup e%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            if (e == 3 || e == 11 || e == 15) begin
                n_vec++;
                if (state !== ((e == 3) ? 2'b01 : (e == 11) ? 2'b10 : 2'b11)) begin
                    n_err++;
                    $display("FAIL startup_state e%0d: got %b", e, state);
                end
            end
            if (e == 14 || e == 15) begin
                n_vec++;
                if ({sys_resetn, ready} !== ((e == 15) ? 2'b11 : 2'b00)) begin
                    n_err++;
                    $display("FAIL startup_latency e%0d: got %b%b", e, sys_resetn, ready);
                end
            end
        end
    endtask

    task automatic test_stable_glitch();
        locked = 1'b1;
        hold_reset();
        for (int e = 1; e <= 30; e++) begin
            locked = (e == 7) ? 1'b0 : 1'b1;
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL stable_glitch e%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
            if (e == 21 || e == 22) begin
                n_vec++;
                if (sys_resetn !== (e == 22) || loss_count !== 8'd0) begin
                    n_err++;
                    $display("FAIL glitch_restart e%0d: got %b/%0d", e, sys_resetn, loss_count);
                end
            end
        end
    endtask

    task automatic test_run_loss();
        locked = 1'b1;
        hold_reset();
        for (int e = 1; e <= 16; e++) cyc();
        locked = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL run_loss k%0d: got %b expected %b", k, dut_vec, exp_vec);
            end
            if (k == 2 || k == 3) begin
                n_vec++;
                if ({state, sys_resetn, loss_count} !== ((k == 3) ? 11'b00_0_00000001 : 11'b11_1_00000000)) begin
                    n_err++;
                    $display("FAIL run_loss_edge k%0d: got %b %b %0d", k, state, sys_resetn, loss_count);
                end
            end
        end
        locked = 1'b1;
        for (int a = 1; a <= 16; a++) begin
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL relock a%0d: got %b expected %b", a, dut_vec, exp_vec);
            end
            if (a == 14 || a == 15) begin
                n_vec++;
                if (sys_resetn !== (a == 15)) begin
                    n_err++;
                    $display("FAIL relock_latency a%0d: got %b", a, sys_resetn);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            for (int c = 0; c < 17; c++) begin
                locked = (c == 0) ? 1'b0 : 1'b1;
                cyc();
                n_vec++;
                if (dut_vec !== exp_vec) begin
                    n_err++;
                    $display("FAIL saturation i%0d c%0d: got %b expected %b", i, c, dut_vec, exp_vec);
                end
            end
        end
        n_vec++;
        if (loss_count !== 8'd255) begin
            n_err++;
            $display("FAIL loss_saturate: got %0d expected 255", loss_count);
        end
        clear_loss = 1'b1;
        cyc();
        clear_loss = 1'b0;
        n_vec++;
        if (loss_count !== 8'd0 || dut_vec !== exp_vec) begin
            n_err++;
            $display("FAIL loss_clear: got %0d expected 0", loss_count);
        end
        locked = 1'b0;
        cyc();
        cyc();
        clear_loss = 1'b1;
        cyc();
        clear_loss = 1'b0;
        n_vec++;
        if (loss_count !== 8'd1 || state !== 2'b00 || dut_vec !== exp_vec) begin
            n_err++;
            $display("FAIL clear_with_loss: got %0d state %b expected 1 state 00", loss_count, state);
        end
    endtask

    task automatic test_async_reset();
        locked = 1'b1;
        hold_reset();
        for (int e = 1; e <= 16; e++) cyc();
        locked = 1'b0;
        cyc();
        locked = 1'b1;
        for (int e = 1; e <= 16; e++) cyc();
        n_vec++;
        if ({ready, loss_count} !== 9'b1_00000001) begin
            n_err++;
            $display("FAIL async_setup: got ready %b loss %0d", ready, loss_count);
        end
        #2 resetn = 1'b0;
        #1;
        n_vec++;
        if ({sys_resetn, sys_reset, ready, loss_count} !== 11'b0_1_0_00000000) begin
            n_err++;
            $display("FAIL async_reset: got %b%b%b %0d expected 010 0", sys_resetn, sys_reset, ready, loss_count);
        end
        @(negedge clock);
        resetn = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL async_restart e%0d: got %b expected %b", e, dut_vec, exp_vec);
            end
        end
    endtask

    task automatic test_random();
        hold_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 99) < 3) locked = ~locked;
            clear_loss = ($urandom_range(0, 99) < 2);
            resetn = ($urandom_range(0, 999) >= 2);
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec) begin
                n_err++;
                $display("FAIL random i%0d: got %b expected %b", i, dut_vec, exp_vec);
            end
        end
        clear_loss = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_no_lock();
        locked = 1'b0;
        hold_reset();
        for (int i = 0; i < 10000; i++) begin
            cyc();
            n_vec++;
            if (dut_vec !== exp_vec || state !== 2'b00 || sys_resetn !== 1'b0) begin
                n_err++;
                $display("FAIL no_lock i%0d: got %b expected %b", i, dut_vec, exp_vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stable_glitch();
        test_run_loss();
        test_saturation();
        test_async_reset();
        test_random();
        test_no_lock();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
